// File: rtl/button_debounce_filter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// button_debounce_filter_pkg : debouncer state encodings and shared timing
// Rev 1.0
// -----------------------------------------------------------------------------
package button_debounce_filter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_LOW       = 2'd0;
  localparam state_t S_WAIT_HIGH = 2'd1;
  localparam state_t S_HIGH      = 2'd2;
  localparam state_t S_WAIT_LOW  = 2'd3;

  // 10 ms qualification and 1 s long press at 100 MHz
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_STABLE_CYCLES     = 1_000_000;
  localparam int DEF_LONG_PRESS_CYCLES = 100_000_000;

  function automatic logic is_wait(input state_t s);
    return (s == S_WAIT_HIGH) || (s == S_WAIT_LOW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce_filter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// button_debounce_filter_if : raw button in, conditioned level/flags out
// Rev 1.0
// -----------------------------------------------------------------------------
interface button_debounce_filter_if;

  logic button_in;
  logic button_out;
  logic long_press_out;
  logic busy_out;

  modport master (
    output button_in,
    input  button_out,
    input  long_press_out,
    input  busy_out
  );

  modport slave (
    input  button_in,
    output button_out,
    output long_press_out,
    output busy_out
  );

endinterface
`default_nettype wire

// File: rtl/button_debounce_filter_sync_chain.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sync_chain : reset-to-0 flop chain bringing an asynchronous level into clk_in
// Rev 1.0
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  wire logic clk_in,
  input  wire logic resetn_in,
  input  wire logic d,
  output logic      q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_debounce_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// button_debounce_filter : synchronise, debounce and long-press detect a button
// Rev 1.0
// -----------------------------------------------------------------------------
module button_debounce_filter
  import button_debounce_filter_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES     = DEF_STABLE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  wire logic                  clk_in,
  input  wire logic                  resetn_in,
  button_debounce_filter_if.slave    btn
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic              sync;
  state_t            state;
  state_t            state_nxt;
  logic [STAB_W-1:0] stab_cnt;
  logic [STAB_W-1:0] stab_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              long_press;
  logic              long_press_nxt;
  logic              button_q;
  logic              busy_q;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk_in    (clk_in),
    .resetn_in (resetn_in),
    .d         (btn.button_in),
    .q         (sync)
  );

  always_comb begin
    state_nxt      = state;
    stab_nxt       = stab_cnt;
    hold_nxt       = hold_cnt;
    long_press_nxt = long_press;
    case (state)
      S_LOW: begin
        if (sync) begin
          state_nxt = S_WAIT_HIGH;
          stab_nxt  = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync) begin
          state_nxt = S_LOW;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = S_HIGH;
        end else begin
          stab_nxt = stab_cnt + STAB_ONE;
        end
      end
      S_HIGH: begin
        // Hold time accumulates across rejected release bounces.
        if (hold_cnt == HOLD_LAST) begin
          long_press_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + HOLD_ONE;
        end
        if (!sync) begin
          state_nxt = S_WAIT_LOW;
          stab_nxt  = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync) begin
          state_nxt = S_HIGH;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt      = S_LOW;
          hold_nxt       = '0;
          long_press_nxt = 1'b0;
        end else begin
          stab_nxt = stab_cnt + STAB_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
      end
    endcase
  end

  // Outputs are flopped from the next state so they switch with the FSM.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state      <= S_LOW;
      stab_cnt   <= '0;
      hold_cnt   <= '0;
      long_press <= 1'b0;
      button_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      stab_cnt   <= stab_nxt;
      hold_cnt   <= hold_nxt;
      long_press <= long_press_nxt;
      button_q   <= (state_nxt == S_HIGH) || (state_nxt == S_WAIT_LOW);
      busy_q     <= is_wait(state_nxt);
    end
  end

  assign btn.button_out     = button_q;
  assign btn.long_press_out = long_press;
  assign btn.busy_out       = busy_q;

endmodule
`default_nettype wire
